// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and memory-write/status bus of the
// instruction-memory loader.
//   rx_data, rx_valid  incoming byte and its one-cycle strobe
//   we, waddr, wdata   one-cycle memory write port
//   cpu_hold           holds the CPU in reset while loading
//   done, error        sticky load-complete / load-failed flags
// Modports: master = loader side, slave = byte source / memory / CPU side.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned WIDTH      = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    input  rx_data, rx_valid,
    output we, waddr, wdata, cpu_hold, done, error
  );

  modport slave (
    output rx_data, rx_valid,
    input  we, waddr, wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads an instruction memory from a byte stream.
// Stream: header byte N (word count), then N words of WIDTH/8 bytes each,
// little-endian. Word k is written to address k mod 2^ADDR_WIDTH. The CPU is
// held in reset until the load completes.
// Optional macro IMEM_LOADER_CHECKSUM_EN: a trailing byte equal to the XOR of
// the header and all data bytes is expected; a mismatch sets error.
// Ports:
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  imem_loader_if.master (rx_data/rx_valid in; we/waddr/wdata,
//        cpu_hold, done, error out)
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned WIDTH      = 32
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.master bus
);
  localparam int unsigned NumBytes = WIDTH / 8;
  localparam int unsigned ByteCntW = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StWrite,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]            word_cnt_q, word_cnt_d;
  logic [7:0]            word_num_q, word_num_d;
  logic [WIDTH-1:0]      asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic                  error_q, error_d;
  localparam state_e     StAfterLoad = StCheck;
`else
  localparam state_e     StAfterLoad = StDone;
`endif

  logic [WIDTH-1:0] asm_next;
  logic             last_byte;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    word_num_d = word_num_q;
    asm_d      = asm_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    error_d    = error_q;
`endif

    // Current assembly buffer with the incoming byte dropped into its lane.
    asm_next = asm_q;
    asm_next[int'(byte_cnt_q) * 8 +: 8] = bus.rx_data;
    last_byte = (byte_cnt_q == ByteCntW'(NumBytes - 1));

    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid) begin
          word_num_d = bus.rx_data;
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = bus.rx_data;
`endif
          state_d    = (bus.rx_data == 8'd0) ? StAfterLoad : StData;
        end
      end
      StData: begin
        if (bus.rx_valid) begin
          asm_d = asm_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
`endif
          if (last_byte) begin
            // Publish the word only now so waddr/wdata hold between writes.
            wdata_d    = asm_next;
            waddr_d    = ADDR_WIDTH'(word_cnt_q);
            byte_cnt_d = '0;
            state_d    = StWrite;
          end else begin
            byte_cnt_d = byte_cnt_q + ByteCntW'(1);
          end
        end
      end
      StWrite: begin
        word_cnt_d = word_cnt_q + 8'd1;
        state_d    = ((word_cnt_q + 8'd1) == word_num_q) ? StAfterLoad : StData;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (bus.rx_valid) begin
          error_d = (bus.rx_data != csum_q);
          state_d = StDone;
        end
      end
`endif
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      word_num_q <= '0;
      asm_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_num_q <= word_num_d;
      asm_q      <= asm_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      error_q    <= error_d;
`endif
    end
  end

  assign bus.we       = (state_q == StWrite);
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.done     = (state_q == StDone);
  assign bus.cpu_hold = (state_q != StDone);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.error    = error_q;
`else
  assign bus.error    = 1'b0;
`endif
endmodule
